// File: rtl/ir_nec_pkg.sv
// Shared types and pulse-width windows for the NEC IR receiver.
// All windows are in 50 us ticks, inclusive on both ends.
package ir_nec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD_MARK,
        ST_LEAD_SPACE,
        ST_BIT_MARK,
        ST_BIT_SPACE
    } nec_state_e;

    localparam logic [7:0] LEAD_MARK_LO  = 8'd160;
    localparam logic [7:0] LEAD_MARK_HI  = 8'd200;
    localparam logic [7:0] LEAD_SPACE_LO = 8'd80;
    localparam logic [7:0] LEAD_SPACE_HI = 8'd100;
    localparam logic [7:0] RPT_SPACE_LO  = 8'd40;
    localparam logic [7:0] RPT_SPACE_HI  = 8'd50;
    localparam logic [7:0] BIT_MARK_LO   = 8'd8;
    localparam logic [7:0] BIT_MARK_HI   = 8'd14;
    localparam logic [7:0] BIT_ZERO_LO   = 8'd8;
    localparam logic [7:0] BIT_ZERO_HI   = 8'd14;
    localparam logic [7:0] BIT_ONE_LO    = 8'd28;
    localparam logic [7:0] BIT_ONE_HI    = 8'd40;

    function automatic logic in_win(input logic [7:0] v, input logic [7:0] lo,
                                    input logic [7:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Longest phase each state may last before it is declared dead.
    function automatic logic [7:0] state_hi(input nec_state_e s);
        case (s)
            ST_LEAD_MARK:  return LEAD_MARK_HI;
            ST_LEAD_SPACE: return (LEAD_SPACE_HI > RPT_SPACE_HI) ? LEAD_SPACE_HI : RPT_SPACE_HI;
            ST_BIT_MARK:   return BIT_MARK_HI;
            ST_BIT_SPACE:  return BIT_ONE_HI;
            default:       return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/ir_tick_gen.sv
// Timing-tick prescaler: one tick every TICK_DIV clocks, realigned on restart.
module ir_tick_gen #(
    parameter int TICK_DIV = 500
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);
    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap;

    assign wrap = (cnt_q == LAST);
    assign tick = wrap & ~restart;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || wrap)
            cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/ir_nec_rx.sv
// NEC IR frame receiver: measures mark/space widths in ticks, decodes
// 32-bit frames and repeat codes, and holds the result for a consumer.
module ir_nec_rx
    import ir_nec_pkg::*;
#(
    parameter int TICK_DIV      = 500,
    parameter bit IR_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ir_in,
    input  logic       ack,
    output logic [7:0] addr,
    output logic [7:0] cmd,
    output logic       valid,
    output logic       rpt,
    output logic       overrun,
    output logic       err
);
    localparam logic SPACE_LVL = IR_ACTIVE_LOW;

    logic        sync1_q, sync2_q, lvl_q;
    logic        is_mark, edge_det, mark_start, mark_end, tick;
    logic [7:0]  phase_q, phase_d;
    nec_state_e  state_q, state_d;
    logic [4:0]  bit_idx_q, bit_idx_d;
    logic [31:0] shift_q, shift_d;
    logic [7:0]  addr_q, addr_d, cmd_q, cmd_d;
    logic        valid_q, valid_d, rpt_q, rpt_d, ovr_q, ovr_d, err_q, err_d;
    logic        timeout, last_bit, bit_zero, bit_one;
    logic        ev_abort, ev_rpt, ev_done, shift_en, idx_clr;
    logic        frame_ok, ev_frame, new_ev;

    // Synchronizer rests at the space level so leaving reset is edge-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= SPACE_LVL;
            sync2_q <= SPACE_LVL;
            lvl_q   <= SPACE_LVL;
        end else begin
            sync1_q <= ir_in;
            sync2_q <= sync1_q;
            lvl_q   <= sync2_q;
        end
    end

    assign is_mark    = sync2_q ^ SPACE_LVL;
    assign edge_det   = sync2_q ^ lvl_q;
    assign mark_start = edge_det & is_mark;
    assign mark_end   = edge_det & ~is_mark;

    ir_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .restart(edge_det),
        .tick   (tick)
    );

    always_comb begin
        phase_d = phase_q;
        if (edge_det)
            phase_d = '0;
        else if (tick && phase_q != 8'hFF)
            phase_d = phase_q + 8'd1;
    end

    assign timeout  = (state_q != ST_IDLE) && (phase_q > state_hi(state_q));
    assign last_bit = (bit_idx_q == 5'd31);
    assign bit_zero = in_win(phase_q, BIT_ZERO_LO, BIT_ZERO_HI);
    assign bit_one  = in_win(phase_q, BIT_ONE_LO, BIT_ONE_HI);

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:
                if (mark_start) state_d = ST_LEAD_MARK;
            ST_LEAD_MARK:
                if (edge_det)
                    state_d = (mark_end && in_win(phase_q, LEAD_MARK_LO, LEAD_MARK_HI))
                              ? ST_LEAD_SPACE : ST_IDLE;
            ST_LEAD_SPACE:
                if (edge_det)
                    state_d = (mark_start && in_win(phase_q, LEAD_SPACE_LO, LEAD_SPACE_HI))
                              ? ST_BIT_MARK : ST_IDLE;
            ST_BIT_MARK:
                if (edge_det)
                    state_d = (mark_end && in_win(phase_q, BIT_MARK_LO, BIT_MARK_HI))
                              ? ST_BIT_SPACE : ST_IDLE;
            ST_BIT_SPACE:
                if (edge_det)
                    state_d = (mark_start && (bit_zero || bit_one) && !last_bit)
                              ? ST_BIT_MARK : ST_IDLE;
            default:
                state_d = ST_IDLE;
        endcase
        if (timeout)
            state_d = ST_IDLE;
    end

    always_comb begin
        ev_abort = 1'b0;
        ev_rpt   = 1'b0;
        ev_done  = 1'b0;
        shift_en = 1'b0;
        idx_clr  = 1'b0;
        case (state_q)
            ST_LEAD_MARK:
                if (edge_det && !(mark_end && in_win(phase_q, LEAD_MARK_LO, LEAD_MARK_HI)))
                    ev_abort = 1'b1;
            ST_LEAD_SPACE:
                if (edge_det) begin
                    if (mark_start && in_win(phase_q, LEAD_SPACE_LO, LEAD_SPACE_HI))
                        idx_clr = 1'b1;
                    else if (mark_start && in_win(phase_q, RPT_SPACE_LO, RPT_SPACE_HI))
                        ev_rpt = 1'b1;
                    else
                        ev_abort = 1'b1;
                end
            ST_BIT_MARK:
                if (edge_det && !(mark_end && in_win(phase_q, BIT_MARK_LO, BIT_MARK_HI)))
                    ev_abort = 1'b1;
            ST_BIT_SPACE:
                if (edge_det) begin
                    if (mark_start && (bit_zero || bit_one)) begin
                        shift_en = 1'b1;
                        ev_done  = last_bit;
                    end else begin
                        ev_abort = 1'b1;
                    end
                end
            default: ;
        endcase
        if (timeout)
            ev_abort = 1'b1;
    end

    // Bits arrive LSB first, so byte0 ends up in shift_d[7:0].
    always_comb begin
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        if (idx_clr)
            bit_idx_d = '0;
        else if (shift_en)
            bit_idx_d = bit_idx_q + 5'd1;
        if (shift_en)
            shift_d = {bit_one, shift_q[31:1]};
    end

    assign frame_ok = (shift_d[31:24] == ~shift_d[23:16]);
    assign ev_frame = ev_done & frame_ok;
    assign new_ev   = ev_frame | ev_rpt;

    // A new event beats a simultaneous ack; overrun only when it lands unacked.
    always_comb begin
        valid_d = valid_q;
        rpt_d   = rpt_q;
        ovr_d   = ovr_q;
        addr_d  = addr_q;
        cmd_d   = cmd_q;
        err_d   = ev_abort | (ev_done & ~frame_ok);
        if (new_ev) begin
            valid_d = 1'b1;
            rpt_d   = ev_rpt;
            ovr_d   = ack ? 1'b0 : (valid_q | ovr_q);
            if (ev_frame) begin
                addr_d = shift_d[7:0];
                cmd_d  = shift_d[23:16];
            end
        end else if (ack) begin
            valid_d = 1'b0;
            rpt_d   = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            addr_q    <= '0;
            cmd_q     <= '0;
            valid_q   <= 1'b0;
            rpt_q     <= 1'b0;
            ovr_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            cmd_q     <= cmd_d;
            valid_q   <= valid_d;
            rpt_q     <= rpt_d;
            ovr_q     <= ovr_d;
            err_q     <= err_d;
        end
    end

    assign addr    = addr_q;
    assign cmd     = cmd_q;
    assign valid   = valid_q;
    assign rpt     = rpt_q;
    assign overrun = ovr_q;
    assign err     = err_q;

endmodule
